// File: rtl/mem_fill_responder_pkg.sv
// ==========================================================================
// mem_fill_responder_pkg: shared constants, request kinds and index helper
// Rev 1.0
// ==========================================================================
`default_nettype none

package mem_fill_responder_pkg;

  localparam int MEM_LATENCY   = 4;
  localparam int WORD_ADDR_LSB = 1;
  localparam int LINE_WORDS    = 8;

  typedef enum logic [1:0] {
    REQ_IDLE  = 2'd0,
    REQ_READ  = 2'd1,
    REQ_WRITE = 2'd2
  } req_kind_e;

  function automatic int word_idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_delay_pipe.sv
// ==========================================================================
// mem_delay_pipe: LATENCY-stage valid+data shift register, valid bits reset
// Rev 1.0
// ==========================================================================
`default_nettype none

module mem_delay_pipe #(
  parameter int LATENCY    = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  any_valid
);

  logic [LATENCY-1:0]    valid_d;
  logic [LATENCY-1:0]    valid_q;
  logic [DATA_WIDTH-1:0] data_d [LATENCY];
  logic [DATA_WIDTH-1:0] data_q [LATENCY];

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Data stages carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    data_q <= data_d;
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];
  assign any_valid = |valid_q;

endmodule

`default_nettype wire

// File: rtl/mem_fill_responder.sv
// ==========================================================================
// mem_fill_responder: word memory answering reads after a fixed latency
// Rev 1.0
// ==========================================================================
`default_nettype none

module mem_fill_responder
  import mem_fill_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 32768,
  parameter int LATENCY    = MEM_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  wr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  busy
);

  localparam int IDX_W = word_idx_width(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0]      idx;
  logic [ADDR_WIDTH-1:0] unused_addr;
  req_kind_e             req_kind;
  logic                  rd_accept;
  logic                  wr_accept;
  logic                  pipe_valid;
  logic [DATA_WIDTH-1:0] pipe_data;

  // Byte lane and bits above the index are dropped, so addresses alias modulo DEPTH.
  assign idx         = addr[WORD_ADDR_LSB +: IDX_W];
  assign unused_addr = addr;

  always_comb begin
    req_kind = REQ_IDLE;
    if (enable && !rst) begin
      req_kind = wr ? REQ_WRITE : REQ_READ;
    end
  end

  assign rd_accept = (req_kind == REQ_READ);
  assign wr_accept = (req_kind == REQ_WRITE);

  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem_q[idx] <= data_in;
    end
  end

  mem_delay_pipe #(
    .LATENCY    (LATENCY),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_delay_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd_accept),
    .in_data   (mem_q[idx]),
    .out_valid (pipe_valid),
    .out_data  (pipe_data),
    .any_valid (busy)
  );

  assign data_valid = pipe_valid;
  assign data_out   = pipe_valid ? pipe_data : '0;

endmodule

`default_nettype wire
